axis_window_sequencer: RTL
==========================

// Module: axis_window_sequencer
// PURPOSE
//  Controller in front of axis_window_multiplier. Tags each input sample with its in-frame
//  index (m_axis_tuser, used as the multiplier's coefficient address) and marks the frame end.
//  Loads new window coefficients into the multiplier's BRAM port A, but only between frames,
//  so a frame never mixes two windows.
// PARAMETERS
//  TDATA_WIDTH   16          sample width, passed through unchanged
//  TUSER_WIDTH   16          m_axis_tuser width; the index is zero-extended (>= ADDR_WIDTH)
//  ADDR_WIDTH    12          coefficient BRAM address width; max frame = 2**ADDR_WIDTH
//  COL_NUM       2           byte-enable columns of the coefficient word
//  COL_WIDTH     8           bits per column
//  DATA_WIDTH    COL_NUM*COL_WIDTH   coefficient word width
// PORTS
//  aclk             in   1            clock
//  aresetn          in   1            asynchronous active-low reset
//  cfg_last_idx     in   ADDR_WIDTH   frame length minus 1; sampled at every frame start
//  s_axis_tdata     in   TDATA_WIDTH  input samples
//  s_axis_tvalid    in   1
//  s_axis_tready    out  1
//  m_axis_tdata     out  TDATA_WIDTH  samples to the multiplier
//  m_axis_tuser     out  TUSER_WIDTH  in-frame sample index
//  m_axis_tvalid    out  1
//  m_axis_tlast     out  1            high on index == latched last_idx
//  m_axis_tready    in   1
//  s_coef_tdata     in   DATA_WIDTH   coefficient words, address 0 first
//  s_coef_tvalid    in   1
//  s_coef_tlast     in   1            last word of the window
//  s_coef_tready    out  1
//  bram_porta_addr  out  ADDR_WIDTH   to the multiplier's port A
//  bram_porta_wrdata out DATA_WIDTH
//  bram_porta_we    out  COL_NUM      all ones on a write, else 0
//  load_done        out  1            one-cycle pulse after the write of the last coefficient
//  err_coef_len     out  1            sticky: last load had word count != last_idx+1
//  frame_cnt        out  32           completed frames; wraps
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; index, address and last_idx registers 0.
//  FSM states IDLE, LOAD, RUN.
//   IDLE: s_coef_tvalid -> LOAD (loading has priority); else s_axis_tvalid -> RUN, latch cfg_last_idx.
//   LOAD: s_coef_tready=1; each handshake writes the word at addr, then addr++.
//         Port A outputs are registered: the write appears 1 cycle after the handshake.
//         Handshake with s_coef_tlast -> IDLE; load_done pulses with that final write.
//         Once addr reaches 2**ADDR_WIDTH-1 and has been written: further words are
//         accepted, we=0 (dropped), until tlast.
//         At tlast: err_coef_len <= (word count != last_idx+1). err is cleared on LOAD entry.
//   RUN:  pass-through, no extra latency:
//         m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready,
//         m_axis_tdata = s_axis_tdata.
//         The index increments on each handshake. On the tlast handshake: frame_cnt++,
//         index -> 0, and then: if s_coef_tvalid -> IDLE, otherwise stay in RUN and latch
//         cfg_last_idx again (back-to-back frames, no bubble).
//  s_coef_tready=0 outside LOAD; s_axis_tready=0 and m_axis_tvalid=0 outside RUN.
//  cfg_last_idx changes mid-frame take effect only at the next frame start.
//  A coefficient stream arriving mid-frame waits; its reload then costs exactly one idle
//  cycle (RUN->IDLE->LOAD).
//  Reset mid-operation: async clear, we=0 immediately, any partial load is abandoned.
//  In LOAD the written address is the low ADDR_WIDTH bits of addr. The word counter is
//  ADDR_WIDTH+1 bits wide and saturates.
// TESTING
//  1 cfg_last_idx=7, 8 coef words 0x0100..0x0107, tlast on the 8th -> we=2'b11 at addr 0..7
//    with matching data; load_done 1 cycle; err_coef_len=0.
//  2 16 samples, m_axis_tready=1 -> tuser 0..7,0..7; tlast on the 8th and 16th; no bubble;
//    frame_cnt=2.
//  3 Random m_axis_tready toggling -> s_axis_tready mirrors it; tdata/tuser stable while stalled;
//    no loss or duplication.
//  4 Coef tvalid raised at index 3 -> s_coef_tready=0 until after the index-7 tlast handshake;
//    then the load runs; next frame starts at tuser 0.
//  5 ADDR_WIDTH=3, cfg_last_idx=7, 10 words -> addr 0..7 written, words 9-10 have we=0, err=1;
//    then a 5-word load -> err=1; then an 8-word load -> err=0.
//  6 aresetn low mid-load and mid-frame -> we, tvalid, load_done = 0 asynchronously;
//    after release state IDLE, tuser=0, frame_cnt=0.

Source files
------------

// File: rtl/axis_window_sequencer.sv
// axis_window_sequencer
// Front-end controller for axis_window_multiplier. Samples pass straight through
// with their in-frame index on m_axis_tuser and tlast on the final index. Window
// coefficients are written into the multiplier's BRAM port A, only between frames.
module axis_window_sequencer #(
  parameter int TDATA_WIDTH = 16,
  parameter int TUSER_WIDTH = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int COL_NUM     = 2,
  parameter int COL_WIDTH   = 8,
  parameter int DATA_WIDTH  = COL_NUM * COL_WIDTH
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [ADDR_WIDTH-1:0]  cfg_last_idx,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  input  logic [DATA_WIDTH-1:0]  s_coef_tdata,
  input  logic                   s_coef_tvalid,
  input  logic                   s_coef_tlast,
  output logic                   s_coef_tready,
  output logic [ADDR_WIDTH-1:0]  bram_porta_addr,
  output logic [DATA_WIDTH-1:0]  bram_porta_wrdata,
  output logic [COL_NUM-1:0]     bram_porta_we,
  output logic                   load_done,
  output logic                   err_coef_len,
  output logic [31:0]            frame_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_MAX = {(ADDR_WIDTH+1){1'b1}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   last_idx_q, last_idx_d;
  // Words accepted in the current load; the MSB marks "address space exhausted".
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [31:0]             frame_cnt_q, frame_cnt_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [COL_NUM-1:0]      we_q, we_d;
  logic                    done_q, done_d;

  logic run, smp_hs, coef_hs, at_last;

  assign run     = (state_q == RUN);
  assign smp_hs  = run && s_axis_tvalid && m_axis_tready;
  assign coef_hs = (state_q == LOAD) && s_coef_tvalid;
  assign at_last = (idx_q == last_idx_q);

  assign s_axis_tready     = run && m_axis_tready;
  assign m_axis_tvalid     = run && s_axis_tvalid;
  assign m_axis_tdata      = run ? s_axis_tdata : '0;
  assign m_axis_tuser      = TUSER_WIDTH'(idx_q);
  assign m_axis_tlast      = run && at_last;
  assign s_coef_tready     = (state_q == LOAD);
  assign bram_porta_addr   = wr_addr_q;
  assign bram_porta_wrdata = wr_data_q;
  assign bram_porta_we     = we_q;
  assign load_done         = done_q;
  assign err_coef_len      = err_q;
  assign frame_cnt         = frame_cnt_q;

  // State register plus all datapath registers; reset clears everything at once.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_idx_q  <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      we_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      we_q        <= we_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: loading wins in IDLE, frames only end on a tlast handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we_d        = '0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_coef_tvalid) begin
          // The length check of this load compares against the current setting.
          state_d    = LOAD;
          cnt_d      = '0;
          err_d      = 1'b0;
          last_idx_d = cfg_last_idx;
        end else if (s_axis_tvalid) begin
          state_d    = RUN;
          last_idx_d = cfg_last_idx;
        end
      end
      LOAD: begin
        if (coef_hs) begin
          if (!cnt_q[ADDR_WIDTH]) begin
            we_d      = '1;
            wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
            wr_data_d = s_coef_tdata;
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          if (s_coef_tlast) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = (cnt_d != ({1'b0, last_idx_q} + CNT_ONE));
          end
        end
      end
      RUN: begin
        if (smp_hs) begin
          if (at_last) begin
            idx_d       = '0;
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (s_coef_tvalid) state_d = IDLE;
            else               last_idx_d = cfg_last_idx;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
